// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_PD1 = 4'd0;
  localparam logic [3:0] OP_PD2 = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_ADC = 4'd4;
  localparam logic [3:0] OP_SBB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_SAR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  localparam int FLG_Z  = 0;
  localparam int FLG_S  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_OF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier; the start edge performs the first of WIDTH steps,
// so done is high in the cycle after the last step and product is final then.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic             busy;

  // product holds {partial sum, remaining multiplier bits}; one add-then-shift per call
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                             input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= a;
        product <= step({{WIDTH{1'b0}}, b}, a);
        cnt     <= CW'(1);
        busy    <= 1'b1;
      end else if (busy) begin
        product <= step(product, mcand);
        cnt     <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete through DONE, MUL runs WIDTH cycles in seq_mul first.
import alu_pkg::*;

module seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [3:0]       i_ALUOp,
  input  logic [WIDTH-1:0] i_Data1,
  input  logic [WIDTH-1:0] i_Data2,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Result,
  output logic             o_Z,
  output logic             o_S,
  output logic             o_C,
  output logic             o_OF
);

  localparam int MSB = WIDTH - 1;

  state_t               state;
  logic [3:0]           flags;
  logic [3:0]           flags_n;
  logic [WIDTH-1:0]     res_n;
  logic [WIDTH:0]       wide;
  logic                 upd;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     mul_res;
  logic                 mul_hi;

  assign is_mul    = MUL_EN && (i_ALUOp == OP_MUL);
  assign mul_start = (state == ST_IDLE) && i_Valid && is_mul;
  assign mul_res   = mul_prod[WIDTH-1:0];
  assign mul_hi    = |mul_prod[2*WIDTH-1:WIDTH];

  assign o_Z  = flags[FLG_Z];
  assign o_S  = flags[FLG_S];
  assign o_C  = flags[FLG_C];
  assign o_OF = flags[FLG_OF];

  generate
    if (MUL_EN) begin : g_mul
      seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (i_CLK),
        .rst_n   (i_RST_N),
        .start   (mul_start),
        .a       (i_Data1),
        .b       (i_Data2),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // Single-cycle datapath evaluated on the live operands, used only on the accepting edge
  always_comb begin
    res_n   = o_Result;
    flags_n = flags;
    wide    = '0;
    upd     = 1'b1;
    case (i_ALUOp)
      OP_PD1: res_n = i_Data1;
      OP_PD2: res_n = i_Data2;
      OP_ADD, OP_ADC: begin
        wide = {1'b0, i_Data1} + {1'b0, i_Data2}
             + {{WIDTH{1'b0}}, (i_ALUOp == OP_ADC) & flags[FLG_C]};
        res_n = wide[WIDTH-1:0];
        flags_n[FLG_C]  = wide[WIDTH];
        flags_n[FLG_OF] = (i_Data1[MSB] == i_Data2[MSB]) && (res_n[MSB] != i_Data1[MSB]);
      end
      OP_SUB, OP_SBB: begin
        wide = {1'b0, i_Data1} - {1'b0, i_Data2}
             - {{WIDTH{1'b0}}, (i_ALUOp == OP_SBB) & flags[FLG_C]};
        res_n = wide[WIDTH-1:0];
        flags_n[FLG_C]  = wide[WIDTH];
        flags_n[FLG_OF] = (i_Data1[MSB] != i_Data2[MSB]) && (res_n[MSB] != i_Data1[MSB]);
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        res_n = (i_ALUOp == OP_AND) ? (i_Data1 & i_Data2) :
                (i_ALUOp == OP_OR)  ? (i_Data1 | i_Data2) :
                (i_ALUOp == OP_XOR) ? (i_Data1 ^ i_Data2) : ~i_Data1;
        flags_n[FLG_C]  = 1'b0;
        flags_n[FLG_OF] = 1'b0;
      end
      OP_SHL: begin
        res_n = {i_Data1[WIDTH-2:0], 1'b0};
        flags_n[FLG_C]  = i_Data1[MSB];
        flags_n[FLG_OF] = 1'b0;
      end
      OP_SHR, OP_SAR: begin
        res_n = {(i_ALUOp == OP_SAR) & i_Data1[MSB], i_Data1[WIDTH-1:1]};
        flags_n[FLG_C]  = i_Data1[0];
        flags_n[FLG_OF] = 1'b0;
      end
      default: upd = 1'b0;
    endcase
    if (upd && i_ALUOp != OP_PD1 && i_ALUOp != OP_PD2) begin
      flags_n[FLG_Z] = (res_n == '0);
      flags_n[FLG_S] = res_n[MSB];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state    <= ST_IDLE;
      o_Ready  <= 1'b1;
      o_Valid  <= 1'b0;
      o_Result <= '0;
      flags    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_Valid <= 1'b0;
          if (i_Valid) begin
            o_Ready <= 1'b0;
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              state   <= ST_DONE;
              o_Valid <= 1'b1;
              if (upd) begin
                o_Result <= res_n;
                flags    <= flags_n;
              end
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state            <= ST_DONE;
            o_Valid          <= 1'b1;
            o_Result         <= mul_res;
            flags[FLG_Z]     <= (mul_res == '0);
            flags[FLG_S]     <= mul_res[MSB];
            flags[FLG_C]     <= mul_hi;
            flags[FLG_OF]    <= mul_hi;
          end
        end
        ST_DONE: begin
          o_Valid <= 1'b0;
          o_Ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
